// File: rtl/time_demux.sv
// Receive-side 4-slot TDM demultiplexer: aligns to sof on slot 0, gathers
// three slots in shadow registers and publishes whole frames on the fourth.
module time_demux #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] sh0_q, sh0_d;
    logic [WIDTH-1:0] sh1_q, sh1_d;
    logic [WIDTH-1:0] sh2_q, sh2_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic [WIDTH-1:0] out3_q, out3_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: once locked we never drop lock except through reset
    always_comb begin
        state_d = state_q;
        if (state_q == ST_UNLOCKED && in_valid && sof) begin
            state_d = ST_LOCKED;
        end
    end

    // Output logic
    always_comb begin
        locked = (state_q == ST_LOCKED);
    end

    // Slot counter, shadow capture and frame publication
    always_comb begin
        slot_d        = slot_q;
        sh0_d         = sh0_q;
        sh1_d         = sh1_q;
        sh2_d         = sh2_q;
        out0_d        = out0_q;
        out1_d        = out1_q;
        out2_d        = out2_q;
        out3_d        = out3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        if (in_valid) begin
            if (sof) begin
                // sof always restarts the frame; mid-frame it discards the partial frame
                sh0_d      = in;
                slot_d     = 2'd1;
                sync_err_d = (state_q == ST_LOCKED) && (slot_q != 2'd0);
            end else if (state_q == ST_LOCKED) begin
                case (slot_q)
                    2'd0: begin
                        sh0_d  = in;
                        slot_d = 2'd1;
                    end
                    2'd1: begin
                        sh1_d  = in;
                        slot_d = 2'd2;
                    end
                    2'd2: begin
                        sh2_d  = in;
                        slot_d = 2'd3;
                    end
                    default: begin
                        out0_d        = sh0_q;
                        out1_d        = sh1_q;
                        out2_d        = sh2_q;
                        out3_d        = in;
                        slot_d        = 2'd0;
                        frame_valid_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q        <= '0;
            sh0_q         <= '0;
            sh1_q         <= '0;
            sh2_q         <= '0;
            out0_q        <= '0;
            out1_q        <= '0;
            out2_q        <= '0;
            out3_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            sh0_q         <= sh0_d;
            sh1_q         <= sh1_d;
            sh2_q         <= sh2_d;
            out0_q        <= out0_d;
            out1_q        <= out1_d;
            out2_q        <= out2_d;
            out3_q        <= out3_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign out0        = out0_q;
    assign out1        = out1_q;
    assign out2        = out2_q;
    assign out3        = out3_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_time_demux.sv
// Directed bench for time_demux: WIDTH=2 instance for the frame scenarios,
// WIDTH=4 instance for full-width capture.
module tb_time_demux;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] in = '0;
    logic       in_valid = 1'b0;
    logic       sof = 1'b0;
    logic [1:0] out0, out1, out2, out3;
    logic       frame_valid, locked, sync_err;

    logic [3:0] in4 = '0;
    logic       in_valid4 = 1'b0;
    logic       sof4 = 1'b0;
    logic [3:0] o40, o41, o42, o43;
    logic       frame_valid4, locked4, sync_err4;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    time_demux #(.WIDTH(2)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .sof(sof),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
    );

    time_demux #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in(in4), .in_valid(in_valid4), .sof(sof4),
        .out0(o40), .out1(o41), .out2(o42), .out3(o43),
        .frame_valid(frame_valid4), .locked(locked4), .sync_err(sync_err4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs away from the edge, then sample just after the edge
    task automatic step(input logic v, input logic s, input logic [1:0] d);
        @(negedge clk);
        in_valid = v;
        sof      = s;
        in       = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pk(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] c, input logic [1:0] d);
        return {24'd0, a, b, c, d};
    endfunction

    function automatic logic [31:0] outs();
        return {24'd0, out0, out1, out2, out3};
    endfunction

    // flags = {locked, frame_valid, sync_err}
    function automatic logic [31:0] flags();
        return {29'd0, locked, frame_valid, sync_err};
    endfunction

    initial begin
        // Reset
        rst = 1'b1;
        step(1'b1, 1'b1, 2'd3);
        rst = 1'b0;
        check("reset_outs", outs(), pk(0, 0, 0, 0));
        check("reset_flags", flags(), 32'b000);
        check("reset_w4", {o40, o41, o42, o43, locked4, frame_valid4}, 18'd0);

        // Unaligned data is discarded
        step(1'b1, 1'b0, 2'd1);
        check("unaligned1_flags", flags(), 32'b000);
        step(1'b1, 1'b0, 2'd2);
        step(1'b1, 1'b0, 2'd3);
        check("unaligned3_flags", flags(), 32'b000);
        check("unaligned_outs", outs(), pk(0, 0, 0, 0));

        // Aligned frame 1,2,3,0
        step(1'b1, 1'b1, 2'd1);
        check("lock_after_sof", flags(), 32'b100);
        step(1'b1, 1'b0, 2'd2);
        step(1'b1, 1'b0, 2'd3);
        check("pre_frame_outs", outs(), pk(0, 0, 0, 0));
        step(1'b1, 1'b0, 2'd0);
        check("frame1_outs", outs(), pk(1, 2, 3, 0));
        check("frame1_flags", flags(), 32'b110);
        step(1'b0, 1'b0, 2'd0);
        check("frame1_pulse_end", flags(), 32'b100);

        // Back-to-back frames with a gap in the second
        step(1'b1, 1'b1, 2'd3);
        step(1'b1, 1'b0, 2'd2);
        step(1'b1, 1'b0, 2'd1);
        step(1'b1, 1'b0, 2'd0);
        check("frame2_outs", outs(), pk(3, 2, 1, 0));
        check("frame2_flags", flags(), 32'b110);
        step(1'b1, 1'b1, 2'd1);
        check("sof_slot0_no_err", flags(), 32'b100);
        step(1'b1, 1'b0, 2'd1);
        step(1'b0, 1'b0, 2'd3);
        check("gap1_flags", flags(), 32'b100);
        step(1'b0, 1'b1, 2'd3);
        check("gap2_outs", outs(), pk(3, 2, 1, 0));
        check("gap2_flags", flags(), 32'b100);
        step(1'b1, 1'b0, 2'd2);
        check("post_gap_no_fv", flags(), 32'b100);
        step(1'b1, 1'b0, 2'd2);
        check("frame3_outs", outs(), pk(1, 1, 2, 2));
        check("frame3_flags", flags(), 32'b110);

        // Misaligned sof at slot 2
        step(1'b1, 1'b1, 2'd2);
        step(1'b1, 1'b0, 2'd3);
        step(1'b1, 1'b1, 2'd1);
        check("sync_err_flags", flags(), 32'b101);
        check("sync_err_outs_hold", outs(), pk(1, 1, 2, 2));
        step(1'b1, 1'b0, 2'd0);
        check("sync_err_pulse_end", flags(), 32'b100);
        step(1'b1, 1'b0, 2'd2);
        step(1'b1, 1'b0, 2'd3);
        check("realign_outs", outs(), pk(1, 0, 2, 3));
        check("realign_flags", flags(), 32'b110);

        // Reset mid-frame while holding frame 1,2,3,0
        step(1'b1, 1'b1, 2'd1);
        step(1'b1, 1'b0, 2'd2);
        step(1'b1, 1'b0, 2'd3);
        step(1'b1, 1'b0, 2'd0);
        check("hold_frame_outs", outs(), pk(1, 2, 3, 0));
        step(1'b1, 1'b1, 2'd3);
        step(1'b1, 1'b0, 2'd3);
        rst = 1'b1;
        step(1'b1, 1'b0, 2'd3);
        rst = 1'b0;
        check("midreset_outs", outs(), pk(0, 0, 0, 0));
        check("midreset_flags", flags(), 32'b000);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 2'(i + 1));
            check("post_reset_no_lock", flags(), 32'b000);
        end
        check("post_reset_outs", outs(), pk(0, 0, 0, 0));
        step(1'b0, 1'b0, 2'd0);

        // WIDTH=4 full-width frame A,5,F,0
        @(negedge clk); in_valid4 = 1'b1; sof4 = 1'b1; in4 = 4'hA;
        @(negedge clk); sof4 = 1'b0; in4 = 4'h5;
        @(negedge clk); in4 = 4'hF;
        @(negedge clk); in4 = 4'h0;
        @(posedge clk); #1;
        check("w4_outs", {16'd0, o40, o41, o42, o43}, 32'h0000A5F0);
        check("w4_flags", {29'd0, locked4, frame_valid4, sync_err4}, 32'b110);
        @(negedge clk); in_valid4 = 1'b0;
        @(posedge clk); #1;
        check("w4_pulse_end", {29'd0, locked4, frame_valid4, sync_err4}, 32'b100);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/time_demux.md
Name: time_demux

Overview:
- Receive-side counterpart of the 4-slot time-division multiplexer.
- Accepts a serial stream of WIDTH-bit symbols, one slot per valid beat, aligned by a start-of-frame marker on slot 0.
- Rebuilds the four parallel channels and presents a complete frame on registered outputs with a one-cycle frame strobe.
- Sits at the far end of the TDM link and feeds per-channel consumers.

Parameters:
- WIDTH, 2, bits per channel symbol; applies to in and out0..out3.
- Channel count is fixed at 4; the slot counter is 2 bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset: synchronous, active-high.
- in  input  WIDTH  serial symbol for the current slot.
- in_valid  input  1  beat qualifier; in and sof are sampled only when high.
- sof  input  1  start of frame; high on a valid beat means this beat is slot 0.
- out0  output  WIDTH  channel 0 of the last complete frame.
- out1  output  WIDTH  channel 1 of the last complete frame.
- out2  output  WIDTH  channel 2 of the last complete frame.
- out3  output  WIDTH  channel 3 of the last complete frame.
- frame_valid  output  1  one-cycle pulse when out0..out3 have just been updated.
- locked  output  1  high once aligned to a sof.
- sync_err  output  1  one-cycle pulse when sof arrives at a slot other than 0 while locked.

Behaviour:
- Reset values (rst high at a rising edge):
  - out0..out3 = 0, frame_valid = 0, sync_err = 0, locked = 0.
  - slot counter = 0, shadow registers sh0..sh2 = 0.
  - rst has priority over all other inputs.
- Two states: UNLOCKED (locked=0) and LOCKED (locked=1).
- UNLOCKED:
  - Valid beats without sof are discarded; the counter stays at 0.
  - A valid beat with sof: sh0 <= in, slot <= 1, go to LOCKED. locked reads 1 from the next cycle.
- LOCKED, valid beat, sof low:
  - slot 0..2: sh[slot] <= in, slot <= slot+1.
  - slot 3: out0 <= sh0, out1 <= sh1, out2 <= sh2, out3 <= in; slot wraps to 0; frame_valid = 1 for exactly the following cycle.
- LOCKED, valid beat, sof high:
  - At slot 0: normal slot-0 capture, no error.
  - At slot 1..3: sync_err = 1 for the following cycle; the partial frame is discarded (outputs untouched, no frame_valid); the beat is taken as slot 0 (sh0 <= in, slot <= 1). Stay LOCKED.
- A missing sof at slot 0 while LOCKED is not an error; the counter free-runs on valid beats.
- in_valid low: the counter, shadows and outputs hold. Gaps of any length are allowed mid-frame.
- Latency: out0..out3 change at the edge that samples the slot-3 beat. frame_valid is high in the cycle immediately after that edge. Back-to-back frames with no gaps give one frame_valid pulse every 4 cycles.
- frame_valid and sync_err are registered, never combinational, and cannot both be high in the same cycle.
- Outputs hold the last complete frame indefinitely. A partial frame never reaches the outputs.
- Reset mid-frame: the partial frame is lost and outputs clear to 0. A new sof is required to relock.

Test Plan:
- Reset then unaligned data: rst 1 cycle, then 3 valid beats without sof -> locked=0, outputs 0, no frame_valid.
- Aligned frame: sof+in=1, then in=2, 3, 0 on consecutive valid beats -> after the 4th edge out0..3 = 1,2,3,0; frame_valid high exactly 1 cycle; locked=1.
- Back-to-back frames with a gap: frames (3,2,1,0) then (1,1,2,2), with in_valid low for 2 cycles between slot 1 and slot 2 of the second frame -> outputs 3,2,1,0, then 1,1,2,2; two frame_valid pulses; no update during the gap.
- Misaligned sof: after slot-0 and slot-1 beats (2,3), sof arrives with in=1, followed by 0, 2, 3 -> sync_err 1 cycle; outputs become 1,0,2,3; one frame_valid only; locked stays 1.
- Reset mid-frame: after 2 beats of a frame with outputs holding a prior frame (1,2,3,0), assert rst -> outputs 0, locked 0; then 4 beats without sof -> no frame_valid.
- WIDTH=4 build: frame 0xA, 0x5, 0xF, 0x0 with sof on the first beat -> out0..3 = A,5,F,0 with full-width capture.
